// File: rtl/counter_ctrl.sv
// -----------------------------------------------------------------------------
// counter_ctrl
// Sequencer for an external N-bit up/down counter. Accepts one command at a
// time (direction, step count, optional clear), clears the counter if asked,
// issues exactly `steps` enable cycles, then pulses o_done. Every output is a
// flop; nothing combinational reaches an output from an input.
//
// Ports
//   i_clk          clock, all state changes on the rising edge
//   i_rst          synchronous active-high reset
//   i_cmd_valid    command request; accepted when o_cmd_ready is also high
//   o_cmd_ready    controller idle and able to take a command
//   i_cmd_dir      1 = count up, 0 = count down
//   i_cmd_steps    number of enable cycles to issue
//   i_cmd_clr      clear the counter before running
//   i_abort        terminate the active command (SETUP/RUN only)
//   i_hold         pause request while running (CTRL_HOLD_EN builds only)
//   i_Q            counter value fed back from the counter
//   o_en           counter enable
//   o_up_down      counter direction
//   o_rst          counter clear
//   o_busy         command in progress
//   o_done         one-cycle completion pulse
//   o_aborted      qualifies o_done: command ended by abort
//   o_wrap         one-cycle pulse after the counter wrapped
//   o_steps_left   enable cycles still to be issued
//
// Build option
//   CTRL_HOLD_EN   defined: i_hold pauses RUN. Undefined: i_hold is ignored.
// -----------------------------------------------------------------------------
// state | meaning
// IDLE  | ready for a command
// SETUP | one cycle: direction/clear presented to the counter, no enable
// RUN   | one enable per cycle until the step count reaches zero
// DONE  | one cycle: o_done pulse, then back to IDLE
// -----------------------------------------------------------------------------
module counter_ctrl #(
  parameter int N = 3,
  parameter int S = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_cmd_valid,
  output logic         o_cmd_ready,
  input  logic         i_cmd_dir,
  input  logic [S-1:0] i_cmd_steps,
  input  logic         i_cmd_clr,
  input  logic         i_abort,
  input  logic         i_hold,
  input  logic [N-1:0] i_Q,
  output logic         o_en,
  output logic         o_up_down,
  output logic         o_rst,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_aborted,
  output logic         o_wrap,
  output logic [S-1:0] o_steps_left
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t r_state;
  logic   r_ready, r_busy, r_en, r_up_down, r_rst, r_done, r_aborted, r_wrap;
  logic [S-1:0] r_steps_left;

  state_t w_state_nxt;
  logic   w_ready_nxt, w_busy_nxt, w_en_nxt, w_ud_nxt, w_rst_nxt;
  logic   w_done_nxt, w_aborted_nxt, w_wrap_nxt;
  logic [S-1:0] w_left_nxt;
  logic [S-1:0] w_left_dec;
  logic   w_run_en;

`ifdef CTRL_HOLD_EN
  assign w_run_en = ~i_hold;
`else
  logic w_hold_unused;
  assign w_hold_unused = i_hold;
  assign w_run_en      = 1'b1;
`endif

  // The enable that is active during this cycle is counted on this edge,
  // whether or not the command ends here.
  assign w_left_dec = r_steps_left - {{(S-1){1'b0}}, r_en};

  assign w_wrap_nxt = r_en & (r_up_down ? (i_Q == {N{1'b1}}) : (i_Q == {N{1'b0}}));

  always_comb begin
    w_state_nxt   = r_state;
    w_ready_nxt   = r_ready;
    w_busy_nxt    = r_busy;
    w_en_nxt      = 1'b0;
    w_ud_nxt      = r_up_down;
    w_rst_nxt     = 1'b0;
    w_done_nxt    = 1'b0;
    w_aborted_nxt = 1'b0;
    w_left_nxt    = r_steps_left;

    unique case (r_state)
      ST_IDLE: begin
        if (i_cmd_valid) begin
          w_state_nxt = ST_SETUP;
          w_ready_nxt = 1'b0;
          w_busy_nxt  = 1'b1;
          w_ud_nxt    = i_cmd_dir;
          w_rst_nxt   = i_cmd_clr;
          w_left_nxt  = i_cmd_steps;
        end
      end

      ST_SETUP: begin
        if ((r_steps_left == '0) || i_abort) begin
          // A zero-step command finishes normally even if abort is also seen.
          w_state_nxt   = ST_DONE;
          w_done_nxt    = 1'b1;
          w_aborted_nxt = (r_steps_left != '0);
        end else begin
          w_state_nxt = ST_RUN;
          w_en_nxt    = 1'b1;
        end
      end

      ST_RUN: begin
        w_left_nxt = w_left_dec;
        if (w_left_dec == '0) begin
          w_state_nxt = ST_DONE;
          w_done_nxt  = 1'b1;
        end else if (i_abort) begin
          w_state_nxt   = ST_DONE;
          w_done_nxt    = 1'b1;
          w_aborted_nxt = 1'b1;
        end else begin
          w_en_nxt = w_run_en;
        end
      end

      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_ready_nxt = 1'b1;
        w_busy_nxt  = 1'b0;
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_ready_nxt = 1'b1;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_ready      <= 1'b1;
      r_busy       <= 1'b0;
      r_en         <= 1'b0;
      r_up_down    <= 1'b1;
      r_rst        <= 1'b0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
      r_wrap       <= 1'b0;
      r_steps_left <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_ready      <= w_ready_nxt;
      r_busy       <= w_busy_nxt;
      r_en         <= w_en_nxt;
      r_up_down    <= w_ud_nxt;
      r_rst        <= w_rst_nxt;
      r_done       <= w_done_nxt;
      r_aborted    <= w_aborted_nxt;
      r_wrap       <= w_wrap_nxt;
      r_steps_left <= w_left_nxt;
    end
  end

  assign o_cmd_ready  = r_ready;
  assign o_busy       = r_busy;
  assign o_en         = r_en;
  assign o_up_down    = r_up_down;
  assign o_rst        = r_rst;
  assign o_done       = r_done;
  assign o_aborted    = r_aborted;
  assign o_wrap       = r_wrap;
  assign o_steps_left = r_steps_left;

endmodule

// File: tb/tb_counter_ctrl.sv
// Self-checking bench for counter_ctrl. A behavioural counter closes the i_Q
// loop; each command's expected outcome (enable count, wrap count, done and
// ready timing, abort flag, residual steps) is worked out from the command's
// parameters before it is issued, then compared with what the DUT produced.
module tb_counter_ctrl;
  localparam int N = 3;
  localparam int S = 8;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         i_cmd_valid;
  logic         o_cmd_ready;
  logic         i_cmd_dir;
  logic [S-1:0] i_cmd_steps;
  logic         i_cmd_clr;
  logic         i_abort;
  logic         i_hold;
  logic [N-1:0] i_Q;
  logic         o_en, o_up_down, o_rst, o_busy, o_done, o_aborted, o_wrap;
  logic [S-1:0] o_steps_left;

  int n_tests = 0;
  int n_fail  = 0;

  logic [N-1:0] q_model = '0;

  counter_ctrl #(.N(N), .S(S)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_dir(i_cmd_dir), .i_cmd_steps(i_cmd_steps), .i_cmd_clr(i_cmd_clr),
    .i_abort(i_abort), .i_hold(i_hold), .i_Q(i_Q),
    .o_en(o_en), .o_up_down(o_up_down), .o_rst(o_rst), .o_busy(o_busy),
    .o_done(o_done), .o_aborted(o_aborted), .o_wrap(o_wrap), .o_steps_left(o_steps_left)
  );

  always #5 i_clk = ~i_clk;

  // The counter being controlled.
  always @(posedge i_clk) begin
    if (o_rst === 1'b1)     q_model <= '0;
    else if (o_en === 1'b1) q_model <= (o_up_down === 1'b1) ? q_model + N'(1) : q_model - N'(1);
  end
  assign i_Q = q_model;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string pfx);
    chk({pfx, "_ready"},   32'(o_cmd_ready),  1);
    chk({pfx, "_en"},      32'(o_en),         0);
    chk({pfx, "_updown"},  32'(o_up_down),    1);
    chk({pfx, "_cntrst"},  32'(o_rst),        0);
    chk({pfx, "_busy"},    32'(o_busy),       0);
    chk({pfx, "_done"},    32'(o_done),       0);
    chk({pfx, "_aborted"}, 32'(o_aborted),    0);
    chk({pfx, "_wrap"},    32'(o_wrap),       0);
    chk({pfx, "_left"},    32'(o_steps_left), 0);
  endtask

  // Edges are numbered from the accept edge (edge 0). abort_at / hold_at
  // name the edge at which the input is sampled high (0 = never).
  task automatic run_cmd(input bit dir, input int steps, input bit clr,
                         input int abort_at, input int hold_at, input int hold_len);
    int hl_eff, d_nat, d_end, en_exp, wrap_exp, left_exp, q0;
    bit abt_exp;
    int en_cnt, wrap_cnt, done_cnt, done_edge, ready_edge, ud_bad, busy_bad;
    logic [S-1:0] left_obs;
    logic abt_obs;
    bit finished;

    hl_eff = 0;
`ifdef CTRL_HOLD_EN
    if (hold_len > 0 && steps > 0 && hold_at >= 2 && hold_at <= steps) hl_eff = hold_len;
`endif
    // Unaborted: enables on edges 2..steps+1 (shifted by any hold), done on the last.
    d_nat = (steps == 0) ? 1 : steps + 1 + hl_eff;
    d_end = (abort_at >= 1 && abort_at < d_nat) ? abort_at : d_nat;
    en_exp = 0;
    for (int j = 2; j <= d_end; j++)
      if (!(j > hold_at && j <= hold_at + hl_eff)) en_exp++;
    left_exp = steps - en_exp;
    abt_exp  = (d_end < d_nat);
    q0       = clr ? 0 : int'(q_model);
    wrap_exp = dir ? (q0 + en_exp) / (1 << N)
                   : (en_exp + (1 << N) - 1 - q0) / (1 << N);

    chk("ready_before_cmd", 32'(o_cmd_ready), 1);
    i_cmd_valid = 1'b1;
    i_cmd_dir   = dir;
    i_cmd_steps = S'(steps);
    i_cmd_clr   = clr;
    i_abort     = 1'b0;
    i_hold      = 1'b0;
    @(negedge i_clk);
    // Junk on the command bus while busy must not be taken.
    i_cmd_dir   = ~dir;
    i_cmd_steps = S'($urandom);
    i_cmd_clr   = ~clr;
    chk("setup_busy",   32'(o_busy),       1);
    chk("setup_ready",  32'(o_cmd_ready),  0);
    chk("setup_en",     32'(o_en),         0);
    chk("setup_updown", 32'(o_up_down),    32'(dir));
    chk("setup_cntrst", 32'(o_rst),        32'(clr));
    chk("setup_left",   32'(o_steps_left), 32'(S'(steps)));

    en_cnt = 0; wrap_cnt = 0; done_cnt = 0; done_edge = -1; ready_edge = -1;
    ud_bad = 0; busy_bad = 0; left_obs = '0; abt_obs = 1'b0; finished = 1'b0;
    for (int e = 1; e <= 200 && !finished; e++) begin
      i_abort     = (e == abort_at);
      i_hold      = (hold_len > 0 && e >= hold_at && e < hold_at + hold_len);
      i_cmd_valid = 1'($urandom_range(0, 1));
      @(negedge i_clk);
      if (o_en === 1'b1) begin
        en_cnt++;
        if (o_up_down !== dir) ud_bad++;
      end
      if (o_wrap === 1'b1) wrap_cnt++;
      if (o_done === 1'b1) begin
        done_cnt++;
        done_edge = e;
        left_obs  = o_steps_left;
        abt_obs   = o_aborted;
      end
      if (o_cmd_ready === 1'b1) begin
        ready_edge = e;
        finished   = 1'b1;
      end else if (o_busy !== 1'b1) busy_bad++;
    end
    i_cmd_valid = 1'b0;
    i_abort     = 1'b0;
    i_hold      = 1'b0;

    chk("cmd_completed",  32'(finished),   1);
    chk("done_pulses",    32'(done_cnt),   1);
    chk("done_edge",      32'(done_edge),  32'(d_end));
    chk("ready_edge",     32'(ready_edge), 32'(d_end + 1));
    chk("en_cycles",      32'(en_cnt),     32'(en_exp));
    chk("wrap_pulses",    32'(wrap_cnt),   32'(wrap_exp));
    chk("left_at_done",   32'(left_obs),   32'(S'(left_exp)));
    chk("aborted_flag",   32'(abt_obs),    32'(abt_exp));
    chk("updown_held",    32'(ud_bad),     0);
    chk("busy_while_cmd", 32'(busy_bad),   0);
  endtask

  initial begin
    bit rd, rc;
    int rs, ra, rh, rl;

    // Reset with a command request held: nothing may be accepted.
    i_rst = 1'b1; i_cmd_valid = 1'b1; i_cmd_dir = 1'b0; i_cmd_steps = 8'd5;
    i_cmd_clr = 1'b1; i_abort = 1'b0; i_hold = 1'b0;
    repeat (3) @(negedge i_clk);
    check_reset("rst_valid_held");
    i_cmd_valid = 1'b0;
    i_rst = 1'b0;
    @(negedge i_clk);
    check_reset("after_rst");

    // Clear, count up 10 from 0: one wrap at 7->0.
    run_cmd(1'b1, 10, 1'b1, 0, 0, 0);
    // Zero steps: SETUP then DONE, no enables.
    run_cmd(1'b0, 0, 1'b0, 0, 0, 0);
    // Down 5, abort sampled during the third enable cycle.
    run_cmd(1'b0, 5, 1'b0, 4, 0, 0);
    // Up 6 with hold high for four sampled edges mid-run.
    run_cmd(1'b1, 6, 1'b0, 0, 3, 4);
    // Abort in SETUP.
    run_cmd(1'b1, 7, 1'b1, 1, 0, 0);

    // Reset in the middle of an 8-step run.
    i_cmd_valid = 1'b1; i_cmd_dir = 1'b1; i_cmd_steps = 8'd8; i_cmd_clr = 1'b0;
    @(negedge i_clk);
    i_cmd_valid = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("midrun_en_before_rst", 32'(o_en), 1);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    check_reset("midrun_rst");
    run_cmd(1'b0, 3, 1'b0, 0, 0, 0);

    for (int t = 0; t < 40; t++) begin
      rd = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      rs = int'($urandom_range(0, 20));
      ra = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, rs + 3)) : 0;
      if (rs >= 2 && $urandom_range(0, 1) == 1) begin
        rh = int'($urandom_range(2, rs));
        rl = int'($urandom_range(1, 4));
      end else begin
        rh = 0;
        rl = 0;
      end
      run_cmd(rd, rs, rc, ra, rh, rl);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge i_clk);
        chk("idle_gap_ready", 32'(o_cmd_ready), 1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
